wb_port_arbiter: RTL and testbench

// - Shares the single register-file write port between two writeback sources: req0 = ALU result, req1 = memory load.
// - Drives the 32-bit data and 5-bit address 2:1 select paths.
// - Round-robin arbitration, valid/ready handshake per requester, optional lock for back-to-back bursts.
// - Sits between the execute/memory stages and the register file. Registered output stage.

---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/wb_grant_fsm.sv | 60 ++++++
 rtl/wb_port_arbiter.sv | 90 +++++++++
 tb/tb_wb_port_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file writeback port arbiter.
// The stall counters in wb_port_arbiter are enabled by defining ARB_STALL_CNT_EN.
package wb_arb_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_grant_fsm.sv
// Round-robin grant FSM with lock ownership; produces the per-requester
// ready signals.
module wb_grant_fsm
    import wb_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0_valid,
    input  logic req0_lock,
    input  logic req1_valid,
    input  logic req1_lock,
    input  logic wb_stall,
    output logic req0_ready,
    output logic req1_ready
);

    arb_state_t state, state_nx;
    logic       last_grant, last_grant_nx;
    logic       grant0, grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
        end
    end

    always_comb begin
        grant0        = 1'b0;
        grant1        = 1'b0;
        state_nx      = state;
        last_grant_nx = last_grant;

        // On contention in IDLE the requester not served last wins.
        unique case (state)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || last_grant);
                grant1 = req1_valid && (!req0_valid || !last_grant);
            end
            OWN0:    grant0 = req0_valid;
            OWN1:    grant1 = req1_valid;
            default: ;
        endcase

        req0_ready = grant0 && !wb_stall;
        req1_ready = grant1 && !wb_stall;

        if (req0_ready) begin
            last_grant_nx = 1'b0;
            state_nx      = req0_lock ? OWN0 : IDLE;
        end else if (req1_ready) begin
            last_grant_nx = 1'b1;
            state_nx      = req1_lock ? OWN1 : IDLE;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-source writeback arbiter (ALU, memory) feeding one register-file
// write port through a registered output stage. Optional: ARB_STALL_CNT_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
`ifdef ARB_STALL_CNT_EN
    parameter int unsigned CNT_W  = CNT_W_DEF,
`endif
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              wb_stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
`ifdef ARB_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt0,
    output logic [CNT_W-1:0]  stall_cnt1,
`endif
    output logic              wr_src
);

    logic              accept;
    logic              sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    wb_grant_fsm u_fsm (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_lock  (req0_lock),
        .req1_valid (req1_valid),
        .req1_lock  (req1_lock),
        .wb_stall   (wb_stall),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready)
    );

    always_comb begin
        accept   = req0_ready || req1_ready;
        sel      = req1_ready;
        sel_addr = sel ? req1_addr : req0_addr;
        sel_data = sel ? req1_data : req0_data;
    end

    // During a stall the whole output stage, wr_en included, is frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_src  <= SRC_ALU;
        end else if (!wb_stall) begin
            wr_en <= accept && (sel_addr != '0);
            if (accept) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
                wr_src  <= sel ? SRC_MEM : SRC_ALU;
            end
        end
    end

`ifdef ARB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt0 <= '0;
            stall_cnt1 <= '0;
        end else begin
            if (req0_valid && !req0_ready && stall_cnt0 != '1)
                stall_cnt0 <= stall_cnt0 + 1'b1;
            if (req1_valid && !req1_ready && stall_cnt1 != '1)
                stall_cnt1 <= stall_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter; counter checks are
// compiled in when ARB_STALL_CNT_EN is defined.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_lock, req0_ready;
    logic        req1_valid, req1_lock, req1_ready;
    logic [4:0]  req0_addr, req1_addr, wr_addr;
    logic [31:0] req0_data, req1_data, wr_data;
    logic        wb_stall, wr_en, wr_src;
`ifdef ARB_STALL_CNT_EN
    logic [15:0] stall_cnt0, stall_cnt1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_W (32),
`ifdef ARB_STALL_CNT_EN
        .CNT_W  (16),
`endif
        .ADDR_W (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_lock  (req0_lock),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_lock  (req1_lock),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wb_stall   (wb_stall),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`ifdef ARB_STALL_CNT_EN
        .stall_cnt0 (stall_cnt0),
        .stall_cnt1 (stall_cnt1),
`endif
        .wr_src     (wr_src)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic l0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic l1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic st);
        req0_valid = v0; req0_lock = l0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_lock = l1; req1_addr = a1; req1_data = d1;
        wb_stall   = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, ".ready0"}, 32'(req0_ready), 32'(r0));
        chk({tag, ".ready1"}, 32'(req1_ready), 32'(r1));
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] a,
                          input logic [31:0] d, input logic s);
        chk({tag, ".wr_en"},   32'(wr_en),   32'(en));
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
        chk({tag, ".wr_data"}, wr_data,      d);
        chk({tag, ".wr_src"},  32'(wr_src),  32'(s));
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0);
        tick(); tick();
        chk_wr("reset", 0, 5'd0, 32'h0, 0);
        chk_rdy("reset", 0, 0);
        reset = 1'b0;

        // Single ALU beat: accepted now, written next cycle.
        drive(1, 0, 5'd5, 32'hDEADBEEF, 0, 0, 5'd0, 32'h0, 0);
        chk_rdy("single", 1, 0);
        tick();
        drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0);
        chk_wr("single", 1, 5'd5, 32'hDEADBEEF, 0);
        tick();
        chk_wr("idle_hold", 0, 5'd5, 32'hDEADBEEF, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_wr("reset2", 0, 5'd0, 32'h0, 0);

        // Contention without lock alternates 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 5'd3, 32'h1000 + 32'(i), 1, 0, 5'd4, 32'h2000 + 32'(i), 0);
            chk_rdy($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
            tick();
            if ((i % 2) == 0) chk_wr($sformatf("rr%0d", i), 1, 5'd3, 32'h1000 + 32'(i), 0);
            else              chk_wr($sformatf("rr%0d", i), 1, 5'd4, 32'h2000 + 32'(i), 1);
        end

        // One ALU beat so the pointer favours MEM next.
        drive(1, 0, 5'd7, 32'h77, 0, 0, 5'd0, 32'h0, 0);
        chk_rdy("pre_lock", 1, 0);
        tick();

        // MEM locks for three beats while ALU waits.
        for (int b = 0; b < 3; b++) begin
            drive(1, 0, 5'd8, 32'h80, 1, b < 2, 5'd9, 32'h900 + 32'(b), 0);
            chk_rdy($sformatf("lock%0d", b), 0, 1);
            tick();
            chk_wr($sformatf("lock%0d", b), 1, 5'd9, 32'h900 + 32'(b), 1);
        end
        drive(1, 0, 5'd8, 32'h80, 0, 0, 5'd0, 32'h0, 0);
        chk_rdy("post_lock", 1, 0);
        tick();
        chk_wr("post_lock", 1, 5'd8, 32'h80, 0);

        // Stall freezes outputs; pointer still favours MEM afterwards.
        for (int s = 0; s < 3; s++) begin
            drive(1, 0, 5'd11, 32'hB0, 1, 0, 5'd10, 32'hB1, 1);
            chk_rdy($sformatf("stall%0d", s), 0, 0);
            tick();
            chk_wr($sformatf("stall%0d", s), 1, 5'd8, 32'h80, 0);
        end
        drive(1, 0, 5'd11, 32'hB0, 1, 0, 5'd10, 32'hB1, 0);
        chk_rdy("unstall", 0, 1);
        tick();
        chk_wr("unstall", 1, 5'd10, 32'hB1, 1);

        // Address zero: accepted, but no write enable.
        drive(1, 0, 5'd0, 32'h1234, 0, 0, 5'd0, 32'h0, 0);
        chk_rdy("zero", 1, 0);
        tick();
        chk_wr("zero", 0, 5'd0, 32'h1234, 0);

        // Enter OWN1, then reset mid-burst.
        drive(0, 0, 5'd0, 32'h0, 1, 1, 5'd12, 32'hC, 0);
        chk_rdy("own1", 0, 1);
        tick();
        chk_wr("own1", 1, 5'd12, 32'hC, 1);
        drive(1, 0, 5'd13, 32'hD, 0, 0, 5'd0, 32'h0, 0);
        chk_rdy("own1_block", 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_wr("rst_burst", 0, 5'd0, 32'h0, 0);
        drive(1, 0, 5'd13, 32'hD, 1, 0, 5'd14, 32'hE, 0);
        chk_rdy("rst_burst_idle", 1, 0);
        tick();
        chk_wr("rst_burst_idle", 1, 5'd13, 32'hD, 0);

`ifdef ARB_STALL_CNT_EN
        reset = 1'b1;
        drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0);
        tick();
        reset = 1'b0;
        chk("cnt0_reset", 32'(stall_cnt0), 32'd0);
        chk("cnt1_reset", 32'(stall_cnt1), 32'd0);
        drive(1, 0, 5'd2, 32'h22, 0, 0, 5'd0, 32'h0, 1);
        tick(); tick(); tick();
        drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0);
        chk("cnt0_stall", 32'(stall_cnt0), 32'd3);
        chk("cnt1_stall", 32'(stall_cnt1), 32'd0);
`endif

        drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
